// File: rtl/gaussian_conv_3x3_if.sv
// Window-in / filtered-pixel-out bus for gaussian_conv_3x3.
interface gaussian_conv_3x3_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_W      = 9,
  parameter int ROW_W      = 10
);
  logic                  frame_start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] p11, p12, p13;
  logic [DATA_WIDTH-1:0] p21, p22, p23;
  logic [DATA_WIDTH-1:0] p31, p32, p33;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_pix;
  logic [COL_W-1:0]      out_col;
  logic [ROW_W-1:0]      out_row;
  logic                  frame_done;

  modport master (
    output frame_start, in_valid, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    input  out_valid, out_pix, out_col, out_row, frame_done
  );

  modport slave (
    input  frame_start, in_valid, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    output out_valid, out_pix, out_col, out_row, frame_done
  );
endinterface

// File: rtl/gaussian_conv_3x3.sv
// 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1] / 16), 3-stage pipeline with
// (col,row) tagging, zeroed border and end-of-frame pulse.
// Optional macro GAUSS_ROUND_EN: round half up instead of truncating.
module gaussian_conv_3x3 #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 640,
  parameter int DATA_WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  gaussian_conv_3x3_if.slave bus
);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW     = DATA_WIDTH + 4;  // 16 * max pixel fits exactly
  localparam int STAGES = 3;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef struct packed {
    logic border;
    logic last;
    col_t col;
    row_t row;
  } tag_t;

  localparam col_t COL_MAX = col_t'(IMG_W - 1);
  localparam row_t ROW_MAX = row_t'(IMG_H - 1);

  col_t col, cur_col, nxt_col;
  row_t row, cur_row, nxt_row;
  tag_t tag_in, tag_s1, tag_s2;

  logic [STAGES-1:0]     vld_pipe;
  logic [SW-1:0]         corner_s1, edge_s1, sum_s2, rnd;
  logic [DATA_WIDTH-1:0] centre_s1;

  logic [DATA_WIDTH-1:0] out_pix;
  col_t                  out_col;
  row_t                  out_row;
  logic                  frame_done;

  // Position of the window arriving this cycle; frame_start tags it (0,0).
  always_comb begin
    cur_col = bus.frame_start ? '0 : col;
    cur_row = bus.frame_start ? '0 : row;
    nxt_col = cur_col;
    nxt_row = cur_row;
    if (bus.in_valid) begin
      if (cur_col == COL_MAX) begin
        nxt_col = '0;
        nxt_row = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
      end else begin
        nxt_col = cur_col + 1'b1;
      end
    end
    tag_in.border = (cur_col == '0) || (cur_col == COL_MAX) ||
                    (cur_row == '0) || (cur_row == ROW_MAX);
    tag_in.last   = (cur_col == COL_MAX) && (cur_row == ROW_MAX);
    tag_in.col    = cur_col;
    tag_in.row    = cur_row;
  end

  // Position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // Valid shift register; frame_start kills everything already in flight
  // but still admits a window arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0] & {(STAGES-1){~bus.frame_start}},
                             bus.in_valid};
  end

  // S1 corner/edge/centre partial sums, S2 weighted total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_s1 <= '0;
      edge_s1   <= '0;
      centre_s1 <= '0;
      tag_s1    <= '0;
      sum_s2    <= '0;
      tag_s2    <= '0;
    end else begin
      corner_s1 <= SW'(bus.p11) + SW'(bus.p13) + SW'(bus.p31) + SW'(bus.p33);
      edge_s1   <= SW'(bus.p12) + SW'(bus.p21) + SW'(bus.p23) + SW'(bus.p32);
      centre_s1 <= bus.p22;
      tag_s1    <= tag_in;
      sum_s2    <= corner_s1 + (edge_s1 << 1) + (SW'(centre_s1) << 2);
      tag_s2    <= tag_s1;
    end
  end

`ifdef GAUSS_ROUND_EN
  assign rnd = sum_s2 + SW'(8);
`else
  assign rnd = sum_s2;
`endif

  // S3 output register; holds its last value between valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pix    <= '0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= vld_pipe[STAGES-2] & ~bus.frame_start & tag_s2.last;
      if (vld_pipe[STAGES-2] && !bus.frame_start) begin
        out_pix <= tag_s2.border ? '0 : DATA_WIDTH'(rnd >> 4);
        out_col <= tag_s2.col;
        out_row <= tag_s2.row;
      end
    end
  end

  assign bus.out_valid  = vld_pipe[STAGES-1];
  assign bus.out_pix    = out_pix;
  assign bus.out_col    = out_col;
  assign bus.out_row    = out_row;
  assign bus.frame_done = frame_done;
endmodule
